move_collector: RTL

- Downstream consumer of the 64 square units' move FIFOs.
- After `start`, it waits until every square reports done. It then walks squares 0..63, pops each square's FIFO through that square's `rden`, and unpacks each 152-bit word into eight 19-bit move slots.
- Valid moves stream out one per cycle on a valid/ready interface to the move-selection stage.
- Move word format is [7b flag][6b from][6b to]. Flag bit 18 is the invalid bit. A FIFO word with all eight invalid bits set is end-of-list for that square.

---
 rtl/move_collector.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/move_collector.sv
// Collects moves from the square units' FIFOs once every square is done, then streams them on a valid/ready port.
// Optional feature macro MOVE_COUNT_EN adds a saturating per-board move_count output.
module move_collector #(
  parameter int NSQ = 64,
  parameter int SQW = 6,
  parameter int TMO = 1023
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [NSQ-1:0]     sq_done,
  input  logic [NSQ*152-1:0] sq_fifo_out,
  output logic [NSQ-1:0]     sq_rden,
  output logic [18:0]        mv_data,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic               busy,
  output logic               list_done,
  output logic               timeout
`ifdef MOVE_COUNT_EN
  ,
  output logic [9:0]         move_count
`endif
);

  localparam int WW    = 152;
  localparam int MW    = 19;
  localparam int SLOTS = 8;
  localparam int CW    = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_LOAD,
    S_EMIT,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [SQW-1:0]   idx_q, idx_d;
  logic [2:0]       slot_q, slot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NSQ-1:0]   rden_d;
  logic [MW-1:0]    mv_data_d;
  logic             mv_valid_d, busy_d, list_done_d, timeout_d;
  logic             pop_d, load_word;
  logic [WW-1:0]    word_q, fifo_word;
  logic [3:0]       load_pick, emit_pick;
  logic [SLOTS-1:0] below_mask;

  // Valid bit per slot is the inverse of the slot's flag bit 18.
  function automatic logic [SLOTS-1:0] valid_mask(input logic [WW-1:0] w);
    logic [SLOTS-1:0] m;
    for (int k = 0; k < SLOTS; k++) m[k] = ~w[MW*k + MW-1];
    return m;
  endfunction

  // Returns {found, index} of the highest set bit.
  function automatic logic [3:0] pick_top(input logic [SLOTS-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < SLOTS; k++) if (m[k]) r = {1'b1, 3'(k)};
    return r;
  endfunction

  assign fifo_word  = sq_fifo_out[WW*int'(idx_q) +: WW];
  assign below_mask = (8'd1 << slot_q) - 8'd1;
  assign load_pick  = pick_top(valid_mask(fifo_word));
  assign emit_pick  = pick_top(valid_mask(word_q) & below_mask);

  // The next move is registered one cycle early, so LOAD presents the first
  // valid slot and every transfer in EMIT presents the following one.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    rden_d      = '0;
    mv_data_d   = mv_data;
    mv_valid_d  = mv_valid;
    busy_d      = busy;
    list_done_d = 1'b0;
    timeout_d   = 1'b0;
    pop_d       = 1'b0;
    load_word   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (&sq_done) begin
          state_d = S_POP;
          idx_d   = '0;
          pop_d   = 1'b1;
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_d     = S_IDLE;
          timeout_d   = 1'b1;
          list_done_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        load_word = 1'b1;
        if (!load_pick[3]) begin
          if (idx_q == SQW'(NSQ - 1)) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_POP;
            pop_d   = 1'b1;
          end
        end else begin
          slot_d     = load_pick[2:0];
          mv_data_d  = fifo_word[MW*int'(load_pick[2:0]) +: MW];
          mv_valid_d = 1'b1;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (mv_ready) begin
          if (emit_pick[3]) begin
            slot_d    = emit_pick[2:0];
            mv_data_d = word_q[MW*int'(emit_pick[2:0]) +: MW];
          end else begin
            mv_valid_d = 1'b0;
            state_d    = S_POP;
            pop_d      = 1'b1;
          end
        end
      end
      S_FIN: begin
        list_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop_d) rden_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      slot_q    <= '0;
      cnt_q     <= '0;
      sq_rden   <= '0;
      mv_data   <= '0;
      mv_valid  <= 1'b0;
      busy      <= 1'b0;
      list_done <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      sq_rden   <= rden_d;
      mv_data   <= mv_data_d;
      mv_valid  <= mv_valid_d;
      busy      <= busy_d;
      list_done <= list_done_d;
      timeout   <= timeout_d;
    end
  end

  // NOTE: the word register is pure datapath, only read after LOAD writes it, so it has no reset.
  always_ff @(posedge clk) begin
    if (load_word) word_q <= fifo_word;
  end

`ifdef MOVE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      move_count <= '0;
    end else if (state_q == S_IDLE && start) begin
      move_count <= '0;
    end else if (mv_valid && mv_ready && move_count != 10'h3FF) begin
      move_count <= move_count + 10'd1;
    end
  end
`endif

endmodule
